// File: rtl/uc_spi_master.sv
// SPI mode-0 initiator (MSB first) with a FWFT tx byte source, a strobed rx
// byte sink, one transaction per start pulse, and a synchronised slave interrupt.
module uc_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] xfer_len,
  input  logic [7:0]  tx_data,
  output logic        tx_strobe,
  output logic [7:0]  rx_data,
  output logic        rx_strobe,
  output logic        busy,
  output logic        done,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso,
  input  logic        look_at_me,
  output logic        attention
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [7:0]  div_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [10:0] byte_cnt_r;
  logic [7:0]  tx_shift_r;
  logic [7:0]  rx_shift_r;
  logic        gap_half_r;
  logic        spi_clk_r;
  logic        spi_cs_r;
  logic        busy_r;
  logic        done_r;
  logic        tx_strobe_r;
  logic        rx_strobe_r;
  logic [7:0]  rx_data_r;
  logic        sync1_r;
  logic        sync2_r;

  logic div_end_s;
  logic accept_s;
  logic rise_evt_s;
  logic fall_evt_s;
  logic last_byte_s;
  logic byte_end_s;
  logic load_s;
  logic hold_end_s;
  logic gap_end_s;

  // Timing events; every half-period of spi_clk ends when the divider wraps.
  assign div_end_s   = (div_cnt_r == DIV_LAST);
  assign accept_s    = (state_r == ST_IDLE) && start && (xfer_len != 11'd0);
  assign rise_evt_s  = (state_r == ST_SHIFT) && div_end_s && !spi_clk_r;
  assign fall_evt_s  = (state_r == ST_SHIFT) && div_end_s && spi_clk_r;
  assign last_byte_s = (byte_cnt_r == 11'd1);
  assign byte_end_s  = fall_evt_s && (bit_cnt_r == 3'd7);
  assign load_s      = accept_s || (byte_end_s && !last_byte_s);
  assign hold_end_s  = (state_r == ST_HOLD) && div_end_s;
  assign gap_end_s   = (state_r == ST_GAP) && div_end_s && gap_half_r;

  // Transaction sequencing.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_SHIFT;
        else          state_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (byte_end_s && last_byte_s) state_s = ST_HOLD;
        else                           state_s = ST_SHIFT;
      end
      ST_HOLD: begin
        if (hold_end_s) state_s = ST_GAP;
        else            state_s = ST_HOLD;
      end
      ST_GAP: begin
        if (gap_end_s) state_s = ST_IDLE;
        else           state_s = ST_GAP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Half-period divider, parked at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               div_cnt_r <= 8'd0;
    else if ((state_r == ST_IDLE) || div_end_s) div_cnt_r <= 8'd0;
    else                                      div_cnt_r <= div_cnt_r + 8'd1;
  end

  // The CS gap is two half-periods long; this flag marks the second one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  gap_half_r <= 1'b0;
    else if (hold_end_s)                         gap_half_r <= 1'b0;
    else if ((state_r == ST_GAP) && div_end_s)   gap_half_r <= 1'b1;
    else                                         gap_half_r <= gap_half_r;
  end

  // Bit and byte counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 11'd0;
    end else if (accept_s) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= xfer_len;
    end else if (fall_evt_s) begin
      bit_cnt_r  <= bit_cnt_r + 3'd1;
      byte_cnt_r <= byte_end_s ? (byte_cnt_r - 11'd1) : byte_cnt_r;
    end else begin
      bit_cnt_r  <= bit_cnt_r;
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // MOSI is the top of the tx shifter; after the last bit it has shifted to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tx_shift_r <= 8'd0;
    else if (load_s)     tx_shift_r <= tx_data;
    else if (fall_evt_s) tx_shift_r <= {tx_shift_r[6:0], 1'b0};
    else                 tx_shift_r <= tx_shift_r;
  end

  // MISO is captured on the cycle spi_clk goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rx_shift_r <= 8'd0;
    else if (rise_evt_s) rx_shift_r <= {rx_shift_r[6:0], spi_miso};
    else                 rx_shift_r <= rx_shift_r;
  end

  // Received byte and byte-stream strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r   <= 8'd0;
      rx_strobe_r <= 1'b0;
      tx_strobe_r <= 1'b0;
    end else begin
      rx_data_r   <= byte_end_s ? rx_shift_r : rx_data_r;
      rx_strobe_r <= byte_end_s;
      tx_strobe_r <= load_s;
    end
  end

  // Serial clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          spi_clk_r <= 1'b0;
    else if (rise_evt_s) spi_clk_r <= 1'b1;
    else if (fall_evt_s) spi_clk_r <= 1'b0;
    else                 spi_clk_r <= spi_clk_r;
  end

  // Chip select, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs_r <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (accept_s)        spi_cs_r <= 1'b0;
      else if (hold_end_s) spi_cs_r <= 1'b1;
      else                 spi_cs_r <= spi_cs_r;
      if (accept_s)        busy_r <= 1'b1;
      else if (gap_end_s)  busy_r <= 1'b0;
      else                 busy_r <= busy_r;
      done_r <= hold_end_s;
    end
  end

  // Two-flop synchroniser for the slave interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= look_at_me;
      sync2_r <= sync1_r;
    end
  end

  assign tx_strobe = tx_strobe_r;
  assign rx_data   = rx_data_r;
  assign rx_strobe = rx_strobe_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign spi_clk   = spi_clk_r;
  assign spi_cs    = spi_cs_r;
  assign spi_mosi  = tx_shift_r[7];
  assign attention = sync2_r;

endmodule

// File: tb/tb_uc_spi_master.sv
// Self-checking bench for uc_spi_master: two instances (half-period 2 and 1),
// a model slave / loopback on MISO, and a monitor that tallies pin activity.
module tb_uc_spi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [10:0] xfer_len = 11'd0;
  logic        look_at_me = 1'b0;
  logic [7:0]  tx_data [2];
  logic [7:0]  rx_data [2];
  logic [1:0]  tx_strobe, rx_strobe, busy, done, spi_clk, spi_cs, spi_mosi, spi_miso, attention;

  always #5 clk = ~clk;

  uc_spi_master #(.CLK_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .xfer_len(xfer_len),
    .tx_data(tx_data[0]), .tx_strobe(tx_strobe[0]), .rx_data(rx_data[0]),
    .rx_strobe(rx_strobe[0]), .busy(busy[0]), .done(done[0]),
    .spi_clk(spi_clk[0]), .spi_cs(spi_cs[0]), .spi_mosi(spi_mosi[0]),
    .spi_miso(spi_miso[0]), .look_at_me(look_at_me), .attention(attention[0])
  );

  uc_spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .xfer_len(xfer_len),
    .tx_data(tx_data[1]), .tx_strobe(tx_strobe[1]), .rx_data(rx_data[1]),
    .rx_strobe(rx_strobe[1]), .busy(busy[1]), .done(done[1]),
    .spi_clk(spi_clk[1]), .spi_cs(spi_cs[1]), .spi_mosi(spi_mosi[1]),
    .spi_miso(spi_miso[1]), .look_at_me(look_at_me), .attention(attention[1])
  );

  int assert_cnt = 0;
  int fail_cnt = 0;

  // Stimulus memories, written only by the test tasks.
  logic [7:0] tx_mem [2][16];
  logic [7:0] resp_mem [2][16];
  int         tx_base [2] = '{0, 0};
  int         rise_base [2] = '{0, 0};
  logic [1:0] loop_en = 2'b00;

  // Monitor tallies, written only by the monitor.
  int   cyc = 0;
  int   tx_cnt [2] = '{0, 0};
  int   rx_cnt [2] = '{0, 0};
  int   done_cnt [2] = '{0, 0};
  int   rise_cnt [2] = '{0, 0};
  int   cs_low [2] = '{0, 0};
  int   busy_cyc [2] = '{0, 0};
  int   last_rx_cyc [2] = '{0, 0};
  int   last_done_cyc [2] = '{0, 0};
  logic prev_clk [2] = '{1'b0, 1'b0};
  logic [7:0] rxlog [2][256];
  logic       mosi_bits [2][1024];

  int s_tx, s_rx, s_done, s_rise, s_cs, s_busy;

  function automatic int hdiv(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // FWFT tx source and the model slave (or loopback) on MISO.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      tx_data[k]  = tx_mem[k][(tx_cnt[k] - tx_base[k]) & 15];
      spi_miso[k] = loop_en[k] ? spi_mosi[k] :
                    resp_mem[k][((rise_cnt[k] - rise_base[k]) >> 3) & 15][7 - ((rise_cnt[k] - rise_base[k]) & 7)];
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      prev_clk[k] <= spi_clk[k];
      if (tx_strobe[k]) tx_cnt[k] <= tx_cnt[k] + 1;
      if (rx_strobe[k]) begin
        rxlog[k][rx_cnt[k] & 255] <= rx_data[k];
        rx_cnt[k] <= rx_cnt[k] + 1;
        last_rx_cyc[k] <= cyc;
      end
      if (done[k]) begin
        done_cnt[k] <= done_cnt[k] + 1;
        last_done_cyc[k] <= cyc;
      end
      if (!spi_cs[k]) cs_low[k] <= cs_low[k] + 1;
      if (busy[k]) busy_cyc[k] <= busy_cyc[k] + 1;
      if (spi_clk[k] && !prev_clk[k]) begin
        mosi_bits[k][rise_cnt[k] & 1023] <= spi_mosi[k];
        rise_cnt[k] <= rise_cnt[k] + 1;
      end
    end
  end

  task automatic snap(input int k);
    #1;
    tx_base[k] = tx_cnt[k];
    rise_base[k] = rise_cnt[k];
    s_tx = tx_cnt[k]; s_rx = rx_cnt[k]; s_done = done_cnt[k];
    s_rise = rise_cnt[k]; s_cs = cs_low[k]; s_busy = busy_cyc[k];
  endtask

  task automatic pulse_start(input int k, input int len);
    @(negedge clk);
    xfer_len = 11'(len);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic run_xfer(input int k, input int len, input bit intrude);
    snap(k);
    pulse_start(k, len);
    for (int c = 0; c < (16 * len + 3) * hdiv(k) + 4; c++) begin
      @(negedge clk);
      if (intrude && c == 10) begin
        xfer_len = 11'd5;
        start[k] = 1'b1;
      end else begin
        start[k] = 1'b0;
      end
    end
    #1;
  endtask

  function automatic logic [7:0] mosi_byte(input int k, input int j);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7 - i] = mosi_bits[k][(s_rise + 8 * j + i) & 1023];
    return b;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      assert_cnt++;
      if ({spi_cs[k], spi_clk[k], spi_mosi[k], busy[k], tx_strobe[k], rx_strobe[k], done[k], attention[k]} !== 8'b1000_0000) begin
        fail_cnt++;
        $display("FAIL reset_pins dut%0d: got %b expected 10000000", k,
                 {spi_cs[k], spi_clk[k], spi_mosi[k], busy[k], tx_strobe[k], rx_strobe[k], done[k], attention[k]});
      end
      assert_cnt++;
      if (rx_data[k] !== 8'h00) begin
        fail_cnt++;
        $display("FAIL reset_rx_data dut%0d: got %h expected 00", k, rx_data[k]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte;
    loop_en[0] = 1'b0;
    tx_mem[0][0] = 8'hA5;
    resp_mem[0][0] = 8'h3C;
    run_xfer(0, 1, 1'b0);
    assert_cnt++;
    if (mosi_byte(0, 0) !== 8'hA5) begin fail_cnt++; $display("FAIL t1_mosi: got %h expected a5", mosi_byte(0, 0)); end
    assert_cnt++;
    if (rx_cnt[0] - s_rx !== 1) begin fail_cnt++; $display("FAIL t1_rx_strobes: got %0d expected 1", rx_cnt[0] - s_rx); end
    assert_cnt++;
    if (rxlog[0][s_rx & 255] !== 8'h3C) begin fail_cnt++; $display("FAIL t1_rx_data: got %h expected 3c", rxlog[0][s_rx & 255]); end
    assert_cnt++;
    if (cs_low[0] - s_cs !== 34) begin fail_cnt++; $display("FAIL t1_cs_low: got %0d expected 34", cs_low[0] - s_cs); end
    assert_cnt++;
    if (done_cnt[0] - s_done !== 1) begin fail_cnt++; $display("FAIL t1_done: got %0d expected 1", done_cnt[0] - s_done); end
    assert_cnt++;
    if (tx_cnt[0] - s_tx !== 1) begin fail_cnt++; $display("FAIL t1_tx_strobes: got %0d expected 1", tx_cnt[0] - s_tx); end
  endtask

  task automatic test_loopback;
    logic [7:0] exp [3];
    exp = '{8'h01, 8'h80, 8'hFF};
    loop_en[1] = 1'b1;
    for (int j = 0; j < 3; j++) tx_mem[1][j] = exp[j];
    run_xfer(1, 3, 1'b0);
    for (int j = 0; j < 3; j++) begin
      assert_cnt++;
      if (rxlog[1][(s_rx + j) & 255] !== exp[j]) begin
        fail_cnt++;
        $display("FAIL t2_rx_byte%0d: got %h expected %h", j, rxlog[1][(s_rx + j) & 255], exp[j]);
      end
    end
    assert_cnt++;
    if (tx_cnt[1] - s_tx !== 3) begin fail_cnt++; $display("FAIL t2_tx_strobes: got %0d expected 3", tx_cnt[1] - s_tx); end
    assert_cnt++;
    if (rise_cnt[1] - s_rise !== 24) begin fail_cnt++; $display("FAIL t2_rises: got %0d expected 24", rise_cnt[1] - s_rise); end
    assert_cnt++;
    if (cs_low[1] - s_cs !== 49) begin fail_cnt++; $display("FAIL t2_cs_low: got %0d expected 49", cs_low[1] - s_cs); end
  endtask

  task automatic test_zero_len;
    snap(0);
    pulse_start(0, 0);
    repeat (20) @(negedge clk);
    #1;
    assert_cnt++;
    if (cs_low[0] - s_cs !== 0) begin fail_cnt++; $display("FAIL t3_cs_low: got %0d expected 0", cs_low[0] - s_cs); end
    assert_cnt++;
    if (busy_cyc[0] - s_busy !== 0) begin fail_cnt++; $display("FAIL t3_busy: got %0d expected 0", busy_cyc[0] - s_busy); end
    assert_cnt++;
    if ((done_cnt[0] - s_done) + (tx_cnt[0] - s_tx) !== 0) begin
      fail_cnt++;
      $display("FAIL t3_done_tx: got %0d expected 0", (done_cnt[0] - s_done) + (tx_cnt[0] - s_tx));
    end
  endtask

  task automatic test_start_while_busy;
    loop_en[0] = 1'b1;
    tx_mem[0][0] = 8'($urandom);
    tx_mem[0][1] = 8'($urandom);
    run_xfer(0, 2, 1'b1);
    repeat (100) @(negedge clk);
    #1;
    assert_cnt++;
    if (rise_cnt[0] - s_rise !== 16) begin fail_cnt++; $display("FAIL t4_rises: got %0d expected 16", rise_cnt[0] - s_rise); end
    assert_cnt++;
    if (done_cnt[0] - s_done !== 1) begin fail_cnt++; $display("FAIL t4_done: got %0d expected 1", done_cnt[0] - s_done); end
    assert_cnt++;
    if (tx_cnt[0] - s_tx !== 2) begin fail_cnt++; $display("FAIL t4_tx_strobes: got %0d expected 2", tx_cnt[0] - s_tx); end
    assert_cnt++;
    if (rxlog[0][(s_rx + 1) & 255] !== tx_mem[0][1]) begin
      fail_cnt++;
      $display("FAIL t4_rx_byte1: got %h expected %h", rxlog[0][(s_rx + 1) & 255], tx_mem[0][1]);
    end
  endtask

  task automatic test_reset_mid;
    bit reached;
    reached = 1'b0;
    loop_en[0] = 1'b1;
    tx_mem[0][0] = 8'h5A;
    tx_mem[0][1] = 8'hC3;
    snap(0);
    pulse_start(0, 2);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (rise_cnt[0] - rise_base[0] >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    assert_cnt++;
    if (!reached) begin fail_cnt++; $display("FAIL t5_reach_bit5: got 0 expected 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    assert_cnt++;
    if ({spi_cs[0], spi_clk[0], busy[0]} !== 3'b100) begin
      fail_cnt++;
      $display("FAIL t5_async_reset: got %b expected 100", {spi_cs[0], spi_clk[0], busy[0]});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_mem[0][0] = 8'h96;
    tx_mem[0][1] = 8'h0F;
    run_xfer(0, 2, 1'b0);
    assert_cnt++;
    if ({rxlog[0][s_rx & 255], rxlog[0][(s_rx + 1) & 255]} !== 16'h960F) begin
      fail_cnt++;
      $display("FAIL t5_clean_rx: got %h expected 960f", {rxlog[0][s_rx & 255], rxlog[0][(s_rx + 1) & 255]});
    end
    assert_cnt++;
    if (cs_low[0] - s_cs !== 66) begin fail_cnt++; $display("FAIL t5_cs_low: got %0d expected 66", cs_low[0] - s_cs); end
  endtask

  task automatic test_attention;
    @(negedge clk);
    look_at_me = 1'b1;
    @(posedge clk);
    #1;
    assert_cnt++;
    if (attention !== 2'b00) begin fail_cnt++; $display("FAIL t6_attn_1clk: got %b expected 00", attention); end
    @(posedge clk);
    #1;
    assert_cnt++;
    if (attention !== 2'b11) begin fail_cnt++; $display("FAIL t6_attn_2clk: got %b expected 11", attention); end
    assert_cnt++;
    if ({spi_cs, spi_clk, spi_mosi, busy} !== 8'b11_00_00_00) begin
      fail_cnt++;
      $display("FAIL t6_pins: got %b expected 11000000", {spi_cs, spi_clk, spi_mosi, busy});
    end
    look_at_me = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit idle_seen;
    idle_seen = 1'b0;
    loop_en[1] = 1'b1;
    snap(1);
    pulse_start(1, 1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy[1]) begin
        idle_seen = 1'b1;
        break;
      end
    end
    xfer_len = 11'd1;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    assert_cnt++;
    if (!(idle_seen && busy[1])) begin fail_cnt++; $display("FAIL b2b_accept: got %b expected 11", {idle_seen, busy[1]}); end
    repeat (30) @(negedge clk);
    #1;
    assert_cnt++;
    if (done_cnt[1] - s_done !== 2) begin fail_cnt++; $display("FAIL b2b_done: got %0d expected 2", done_cnt[1] - s_done); end
    assert_cnt++;
    if (busy_cyc[1] - s_busy !== 38) begin fail_cnt++; $display("FAIL b2b_busy: got %0d expected 38", busy_cyc[1] - s_busy); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      int k, len, h;
      k = int'($urandom_range(1, 0));
      len = int'($urandom_range(4, 1));
      h = hdiv(k);
      loop_en[k] = 1'($urandom);
      for (int j = 0; j < 16; j++) begin
        tx_mem[k][j] = 8'($urandom);
        resp_mem[k][j] = 8'($urandom);
      end
      run_xfer(k, len, 1'b0);
      for (int j = 0; j < len; j++) begin
        assert_cnt++;
        if (mosi_byte(k, j) !== tx_mem[k][j]) begin
          fail_cnt++;
          $display("FAIL rnd_mosi n%0d b%0d: got %h expected %h", n, j, mosi_byte(k, j), tx_mem[k][j]);
        end
        assert_cnt++;
        if (rxlog[k][(s_rx + j) & 255] !== (loop_en[k] ? tx_mem[k][j] : resp_mem[k][j])) begin
          fail_cnt++;
          $display("FAIL rnd_rx n%0d b%0d: got %h expected %h", n, j, rxlog[k][(s_rx + j) & 255],
                   loop_en[k] ? tx_mem[k][j] : resp_mem[k][j]);
        end
      end
      assert_cnt++;
      if (tx_cnt[k] - s_tx !== len || rx_cnt[k] - s_rx !== len || done_cnt[k] - s_done !== 1) begin
        fail_cnt++;
        $display("FAIL rnd_counts n%0d: got tx%0d rx%0d done%0d expected tx%0d rx%0d done1", n,
                 tx_cnt[k] - s_tx, rx_cnt[k] - s_rx, done_cnt[k] - s_done, len, len);
      end
      assert_cnt++;
      if (rise_cnt[k] - s_rise !== 8 * len) begin
        fail_cnt++;
        $display("FAIL rnd_rises n%0d: got %0d expected %0d", n, rise_cnt[k] - s_rise, 8 * len);
      end
      assert_cnt++;
      if (cs_low[k] - s_cs !== (16 * len + 1) * h) begin
        fail_cnt++;
        $display("FAIL rnd_cs_low n%0d: got %0d expected %0d", n, cs_low[k] - s_cs, (16 * len + 1) * h);
      end
      assert_cnt++;
      if (busy_cyc[k] - s_busy !== (16 * len + 3) * h) begin
        fail_cnt++;
        $display("FAIL rnd_busy n%0d: got %0d expected %0d", n, busy_cyc[k] - s_busy, (16 * len + 3) * h);
      end
      assert_cnt++;
      if (last_done_cyc[k] - last_rx_cyc[k] !== h) begin
        fail_cnt++;
        $display("FAIL rnd_rx_to_done n%0d: got %0d expected %0d", n, last_done_cyc[k] - last_rx_cyc[k], h);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 16; j++) begin
        tx_mem[k][j] = 8'h00;
        resp_mem[k][j] = 8'h00;
      end
    end
    test_reset();
    test_single_byte();
    test_loopback();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid();
    test_attention();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
